// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, one step per cycle.
// Define MULDIV_FASTMUL_EN to replace the iterative multiply with a single-cycle registered multiplier.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0]  hi_reg, lo_reg, d_reg, result_reg;
    logic [2:0]       op_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             neg_reg, sa_reg;

    // Operand decode at accept time
    logic            signed_a, signed_b, sa_in, sb_in, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;

    assign signed_a = !(op == 3'd3 || op == 3'd5 || op == 3'd7);
    assign signed_b = (op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd6);
    assign sa_in    = signed_a & a[XLEN-1];
    assign sb_in    = signed_b & b[XLEN-1];
    assign mag_a    = sa_in ? -a : a;
    assign mag_b    = sb_in ? -b : b;
    assign div_zero = (b == '0);
    assign div_ovf  = (op == 3'd4 || op == 3'd6) && (a == INT_MIN) && (b == '1);

    // One iteration step; hi/lo hold {acc, multiplier} for mul, {remainder, dividend/quotient} for div
    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ge;
    logic [XLEN-1:0] step_hi, step_lo;

    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, d_reg} : '0);
    assign div_shift = {hi_reg, lo_reg[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, d_reg});

    always_comb begin
        step_hi = mul_sum[XLEN:1];
        step_lo = {mul_sum[0], lo_reg[XLEN-1:1]};
        if (op_reg[2]) begin
            step_hi = div_ge ? (div_shift[XLEN-1:0] - d_reg) : div_shift[XLEN-1:0];
            step_lo = {lo_reg[XLEN-2:0], div_ge};
        end
    end

    // Sign correction applied to the final step's outputs
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   quo_c, rem_c, final_res;

    assign prod_c    = neg_reg ? -{step_hi, step_lo} : {step_hi, step_lo};
    assign quo_c     = neg_reg ? -step_lo : step_lo;
    assign rem_c     = sa_reg ? -step_hi : step_hi;
    assign final_res = op_reg[2] ? (op_reg[1] ? rem_c : quo_c)
                     : ((op_reg[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN]);

`ifdef MULDIV_FASTMUL_EN
    logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
    logic [XLEN-1:0]   fast_res;

    assign ext_a     = {{XLEN{sa_in}}, a};
    assign ext_b     = {{XLEN{sb_in}}, b};
    assign fast_prod = ext_a * ext_b;
    assign fast_res  = (op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

    assign in_ready  = (state_reg == S_IDLE) && !kill && !rst;
    assign out_valid = (state_reg == S_DONE);
    assign result    = result_reg;
    assign out_tag   = tag_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            d_reg      <= '0;
            result_reg <= '0;
            op_reg     <= '0;
            tag_reg    <= '0;
            neg_reg    <= 1'b0;
            sa_reg     <= 1'b0;
        end else if (kill) begin
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_reg  <= op;
                        tag_reg <= tag;
                        neg_reg <= sa_in ^ sb_in;
                        sa_reg  <= sa_in;
                        cnt_reg <= CNT_W'(XLEN-1);
                        hi_reg  <= '0;
                        if (op[2]) begin
                            lo_reg <= mag_a;
                            d_reg  <= mag_b;
                            // Degenerate divides resolve without iterating
                            if (div_zero) begin
                                result_reg <= op[1] ? a : '1;
                                state_reg  <= S_DONE;
                            end else if (div_ovf) begin
                                result_reg <= op[1] ? '0 : a;
                                state_reg  <= S_DONE;
                            end else begin
                                state_reg <= S_BUSY;
                            end
                        end else begin
`ifdef MULDIV_FASTMUL_EN
                            result_reg <= fast_res;
                            state_reg  <= S_DONE;
`else
                            lo_reg    <= mag_b;
                            d_reg     <= mag_a;
                            state_reg <= S_BUSY;
`endif
                        end
                    end
                end
                S_BUSY: begin
                    hi_reg <= step_hi;
                    lo_reg <= step_lo;
                    if (cnt_reg == '0) begin
                        result_reg <= final_res;
                        state_reg  <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected results, a monitor pops and compares on output.
module tb_muldiv_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = '0;
    logic [XLEN-1:0]  a = '0;
    logic [XLEN-1:0]  b = '0;
    logic [TAG_W-1:0] tag = '0;
    logic             kill = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit hold = 1'b0;

    typedef struct {
        logic [XLEN-1:0]  res;
        logic [TAG_W-1:0] tg;
        int               acc;
        int               lat;
    } exp_t;
    exp_t sb[$];

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .tag(tag), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model from the RISC-V M-extension definitions
    function automatic logic [XLEN-1:0] ref_result(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        longint sx, sy, ux, uy, p;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
            3'd4: begin
                if (y == 0) return '1;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return '1;
                p = ux / uy; return p[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return '0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        if (o[2] && y == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return XLEN'($urandom_range(0, 15));
            default: return XLEN'($urandom);
        endcase
    endfunction

    // Called shortly after a rising edge; returns once the op has been accepted.
    task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                         input logic [XLEN-1:0] er, input int el, output int waits);
        exp_t e;
        in_valid = 1'b1;
        op  = o;
        a   = x;
        b   = y;
        tag = TAG_W'($urandom);
        #1;
        waits = 0;
        while (!in_ready) begin
            @(posedge clk);
            #2;
            waits++;
            if (waits > 300) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
                in_valid = 1'b0;
                return;
            end
        end
        e.res = er;
        e.tg  = tag;
        e.acc = cyc;
        e.lat = el;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor
    initial begin
        bit   was_valid = 1'b0;
        bit   prev_hs = 1'b0;
        int   first_cyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                was_valid = 1'b0;
                prev_hs   = 1'b0;
            end else begin
                if (prev_hs && !kill) check("idle_after_handshake_in_ready", XLEN'(in_ready), 1);
                prev_hs = 1'b0;
                if (out_valid) begin
                    if (!was_valid) first_cyc = cyc;
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_output: out_valid=1 result=%h, required no output", result);
                    end else begin
                        e = sb[0];
                        check("result", result, e.res);
                        check("out_tag", XLEN'(out_tag), XLEN'(e.tg));
                        check("in_ready_in_done", XLEN'(in_ready), 0);
                        if (out_ready) begin
                            check("latency", XLEN'(first_cyc - e.acc), XLEN'(e.lat));
                            void'(sb.pop_front());
                            prev_hs = 1'b1;
                        end
                    end
                    was_valid = !out_ready;
                end else begin
                    was_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w;
        logic [2:0] ro;
        logic [XLEN-1:0] ra, rb;

        repeat (3) @(posedge clk);
        #2;
        check("reset_in_ready", XLEN'(in_ready), 0);
        check("reset_out_valid", XLEN'(out_valid), 0);
        check("reset_result", result, 0);
        check("reset_out_tag", XLEN'(out_tag), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("post_reset_in_ready", XLEN'(in_ready), 1);
        @(posedge clk);
        #1;

        issue(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, w);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, w);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, w);
        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, w);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, w);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, w);
        issue(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  w);
        issue(3'd7, 32'd5,         32'd0,         32'd5,         1,  w);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  w);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  w);
        issue(3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1,  w);
        issue(3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1,  w);
        drain();

        // Backpressure: hold out_ready low for 10 cycles once the result appears
        @(posedge clk);
        #1;
        hold = 1'b1;
        issue(3'd5, 32'd100, 32'd7, 32'd14, 33, w);
        w = 0;
        while (!out_valid && w < 100) begin
            @(posedge clk);
            #2;
            w++;
        end
        check("backpressure_out_valid_seen", XLEN'(out_valid), 1);
        repeat (10) @(posedge clk);
        #2;
        hold = 1'b0;
        drain();

        // kill five cycles into a divide; the next op is accepted the following cycle
        @(posedge clk);
        #1;
        issue(3'd4, 32'd1000, 32'd3, 32'd333, 33, w);
        repeat (4) @(posedge clk);
        #1;
        kill = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 kill = 1'b0;
        #1 check("kill_out_valid", XLEN'(out_valid), 0);
        issue(3'd7, 32'd1000, 32'd3, 32'd1, 33, w);
        check("kill_next_accept_waits", XLEN'(w), 0);
        drain();

        // Reset in the middle of an operation
        @(posedge clk);
        #1;
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, ref_result(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), 33, w);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        #1 check("rst_cycle_in_ready", XLEN'(in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_out_valid", XLEN'(out_valid), 0);
        check("rst_mid_result", result, 0);
        check("rst_mid_in_ready", XLEN'(in_ready), 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            issue(ro, ra, rb, ref_result(ro, ra, rb), ref_lat(ro, ra, rb), w);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
